// File: rtl/value_change_publisher.sv
// Samples a value every clock and publishes each change as a {prev, new} event
// through a small show-ahead FIFO with sticky overflow and a saturating drop counter.
module value_change_publisher #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         value,
    input  logic                     ev_ready,
    input  logic                     clr_ovf,
    output logic                     ev_valid,
    output logic [WIDTH-1:0]         ev_new,
    output logic [WIDTH-1:0]         ev_prev,
    output logic                     ev_first,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] memNew_q   [DEPTH];
    logic [WIDTH-1:0] memPrev_q  [DEPTH];
    logic             memFirst_q [DEPTH];

    logic [AW:0]      wrPtr_q, wrPtr_d;
    logic [AW:0]      rdPtr_q, rdPtr_d;
    logic [WIDTH-1:0] lastSeen_q;
    logic             primed_q;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] dropCnt_q, dropCnt_d;

    logic [AW:0]      levelNow;
    logic             full;
    logic             change;
    logic             pop;
    logic             push;
    logic             drop;

    // The 4-state compare lets X/Z on the input register as a change in simulation;
    // hardware sees an ordinary inequality.
    always_comb begin
        levelNow = wrPtr_q - rdPtr_q;
        full     = (levelNow == FULL_LEVEL);
        change   = !primed_q || (value !== lastSeen_q);
        pop      = (levelNow != '0) && ev_ready;
        push     = change && (!full || pop);
        drop     = change && full && !pop;

        wrPtr_d  = push ? wrPtr_q + 1'b1 : wrPtr_q;
        rdPtr_d  = pop  ? rdPtr_q + 1'b1 : rdPtr_q;

        ovf_d     = ovf_q;
        dropCnt_d = dropCnt_q;
        if (clr_ovf) begin
            ovf_d     = 1'b0;
            dropCnt_d = drop ? CNT_W'(1) : '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (dropCnt_q != '1) begin
                dropCnt_d = dropCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            lastSeen_q <= '0;
            primed_q   <= 1'b0;
            ovf_q      <= 1'b0;
            dropCnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                memNew_q[i]   <= '0;
                memPrev_q[i]  <= '0;
                memFirst_q[i] <= 1'b0;
            end
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            lastSeen_q <= value;
            primed_q   <= 1'b1;
            ovf_q      <= ovf_d;
            dropCnt_q  <= dropCnt_d;
            if (push) begin
                memNew_q[wrPtr_q[AW-1:0]]   <= value;
                memPrev_q[wrPtr_q[AW-1:0]]  <= lastSeen_q;
                memFirst_q[wrPtr_q[AW-1:0]] <= !primed_q;
            end
        end
    end

    assign ev_valid = (levelNow != '0);
    assign ev_new   = memNew_q[rdPtr_q[AW-1:0]];
    assign ev_prev  = memPrev_q[rdPtr_q[AW-1:0]];
    assign ev_first = memFirst_q[rdPtr_q[AW-1:0]];
    assign level    = levelNow;
    assign ovf      = ovf_q;
    assign drop_cnt = dropCnt_q;

endmodule

// File: doc/value_change_publisher.md
Name: value_change_publisher

Overview:
- Transmit side of the value-change interface: samples a WIDTH-bit input every clock and detects changes.
- Each change is queued as a {previous, new} event and offered downstream on a valid/ready handshake.
- Downstream change monitors consume these events instead of polling the value.
- Includes a DEPTH-entry event FIFO with overflow accounting, so monitors may stall without corrupting event order.

Parameters:
- WIDTH, 4, bit width of the sampled value and of each event field.
- DEPTH, 2, number of queued events; power of two, minimum 2.
- CNT_W, 8, width of the saturating dropped-event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- value  input  WIDTH  monitored value, sampled every rising edge.
- ev_ready  input  1  downstream accepts the head event.
- clr_ovf  input  1  clears ovf and drop_cnt.
- ev_valid  output  1  head event available.
- ev_new  output  WIDTH  value after the change.
- ev_prev  output  WIDTH  value before the change; 0 for the first event after reset.
- ev_first  output  1  head event is the post-reset initial event.
- level  output  clog2(DEPTH)+1  FIFO occupancy.
- ovf  output  1  sticky: at least one event dropped.
- drop_cnt  output  CNT_W  dropped events, saturating at all-ones.

Behaviour:
- Reset, clk edge with rst_n=0:
  - Outputs: ev_valid=0, ev_new=0, ev_prev=0, ev_first=0, level=0, ovf=0, drop_cnt=0.
  - Internal state: last_seen=0, primed=0, FIFO pointers=0.
  - Reset takes priority over every other input, including mid-handshake.
  - Queued events are discarded with no drop accounting.
- Change detect at each edge with rst_n=1, using `value` as present before the edge:
  - change = !primed || (value != last_seen).
  - last_seen <= value and primed <= 1 unconditionally, whether or not the push succeeds.
  - First sample after reset always generates an event with ev_first=1 and prev=0, even if value==0.
- Push: when change=1, the entry {first=!primed, prev=last_seen, new=value} is written at the tail.
- Pop: occurs when ev_valid && ev_ready at the edge; head advances.
- Full boundary:
  - A push while level==DEPTH and no pop at the same edge is dropped.
  - On a drop: ovf<=1; drop_cnt<=drop_cnt+1, saturating.
  - Push and pop at the same edge while full: both succeed, level unchanged, no drop.
- Empty boundary: push with no pop raises level 0->1; ev_valid=1 the cycle after the sampling edge. Latency from value change to ev_valid is 1 clock.
- Show-ahead: ev_new/ev_prev/ev_first reflect the head entry combinationally from FIFO storage; ev_valid = (level!=0).
- Holding: when ev_valid=1 and ev_ready=0, the head fields stay stable until popped.
- Ordering: events are delivered strictly in sampling order. No coalescing of back-to-back changes; A->B->A yields two events.
- clr_ovf:
  - Clears ovf and drop_cnt at the edge.
  - If a drop occurs at the same edge, clear wins for ovf; drop_cnt becomes 1.
- Pointers wrap modulo DEPTH. level is computed from the pointer difference with an extra wrap bit.
- Simulation: X/Z bits on value count as a change (use a 4-state compare in the behavioural check only). Synthesised logic is 2-state.

Test Plan:
1. Reset held 3 clocks with value=5, release, ev_ready=1 -> one event: first=1, prev=0, new=5, ev_valid for exactly 1 cycle; then ev_valid=0 while value stays 5.
2. Primed with value 5, then drive 5->9->5 on successive edges, ev_ready=1 -> events (5,9) then (9,5), each valid 1 cycle after its sampling edge; level never exceeds 1.
3. ev_ready=0, DEPTH=2, value changes 1->2->3->4 (3 changes after primed) -> level saturates at 2; queue holds (1,2),(2,3); ovf=1, drop_cnt=1; then ev_ready=1 drains (1,2),(2,3), after which no further event.
4. Full FIFO, ev_ready=1 on the same edge as a new change -> pop and push both occur, level stays 2, ovf stays 0, order preserved.
5. ovf set with drop_cnt=3, pulse clr_ovf on an edge with a simultaneous drop -> ovf=0, drop_cnt=1; clr_ovf alone -> drop_cnt=0.
6. Two events queued, assert rst_n=0 for 1 clock mid-handshake -> ev_valid=0, level=0. After release with value=7 -> single first=1 event (0,7).
